dfh_chain_walker: RTL and testbench
===================================

// Module: dfh_chain_walker
// PURPOSE
//  Hardware DFH list walker: starting at a base address, issues 64-bit CSR reads,
//  decodes each Device Feature Header, follows nxt_dfh_offset until EOL/zero offset.
//  Streams each header out for checking; reports count and typed error status.
//  Sits beside the BAR0 CSR fabric as a self-discovery/built-in-check engine.
// PARAMETERS
//  ADDR_W       32   byte-address width of CSR read port
//  MAX_DFH      32   max headers walked before ERR_MAXLEN (>=1)
//  TIMEOUT_CYC  1024 cycles allowed from read accept to response (>=2)
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous reset, active-high
//  start          in   1       pulse: begin walk (ignored while busy)
//  base_addr      in   ADDR_W  address of first DFH; sampled on accepted start
//  rd_req_valid   out  1       read request valid
//  rd_req_ready   in   1       read request ready
//  rd_req_addr    out  ADDR_W  read byte address (8B aligned)
//  rd_rsp_valid   in   1       read response valid (no backpressure)
//  rd_rsp_data    in   64      read data = DFH
//  busy           out  1       walk in progress
//  done           out  1       sticky: walk ended cleanly
//  err            out  1       sticky: walk aborted
//  err_code       out  3       0 none,1 TIMEOUT,2 MAXLEN,3 ADDR_OVF,4 MISALIGN
//  entry_valid    out  1       1-cycle pulse per decoded header
//  entry_idx      out  $clog2(MAX_DFH+1)  index of header (0-based)
//  entry_addr     out  ADDR_W  address header was read from
//  entry_dfh      out  64      raw header value
//  dfh_count      out  $clog2(MAX_DFH+1)  headers decoded so far
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-walk abandons it; late
//   responses after reset are ignored (FSM not in WAIT).
//  DFH fields: feat_id[11:0], major[15:12], nxt_off[39:16], eol[40], feat_type[63:60].
//  FSM IDLE/DONE/ERR --start--> REQ: cur<=base_addr, done/err/err_code/dfh_count<=0.
//   start accepted when busy=0; rd_req_valid asserted the following cycle.
//   base_addr[2:0]!=0 on start -> ERR, code MISALIGN, no read issued.
//  REQ: rd_req_valid=1, rd_req_addr=cur, held stable until rd_req_ready -> WAIT.
//  WAIT: one outstanding read; rd_rsp_valid accepted only here (>=1 cycle after
//   accept; stray responses elsewhere dropped). Timer counts from 0 on entry;
//   reaching TIMEOUT_CYC without response -> ERR, TIMEOUT.
//  On response (same cycle): entry_valid=1 next cycle with idx=dfh_count,
//   entry_addr=cur, entry_dfh=data; dfh_count increments; then, in priority:
//   1 eol=1 or nxt_off==0 -> DONE (final header still reported)
//   2 dfh_count+1==MAX_DFH -> ERR, MAXLEN
//   3 nxt_off[2:0]!=0 -> ERR, MISALIGN
//   4 cur+nxt_off computed in ADDR_W+1 bits; carry -> ERR, ADDR_OVF
//   else cur<=cur+nxt_off, -> REQ.
//  busy=1 in REQ/WAIT; done=1 in DONE; err=1 in ERR; sticky until next start.
//  dfh_count saturates at MAX_DFH; never wraps.
//  start coincident with response or while busy: ignored.
// TESTING
//  1 Chain 0x0->+0x1000->+0x2000(eol), ready=1, 2-cycle rsp -> 3 entry pulses,
//    addrs 0x0/0x1000/0x3000, done=1, dfh_count=3, err=0.
//  2 No response for 1024 cycles after first accept -> err=1, err_code=1, busy=0;
//    late rsp then ignored (no entry_valid).
//  3 MAX_DFH=4, every header nxt_off=0x1000 eol=0 -> 4 entries, err_code=2.
//  4 ADDR_W=16, cur=0xF000, nxt_off=0x2000 -> err_code=3, entry for 0xF000 still emitted;
//    nxt_off=0x1004 -> err_code=4.
//  5 rd_req_ready low 5 cycles: addr stable; start pulse while busy ignored;
//    rst asserted in WAIT -> all outputs 0 next cycle, new start walks cleanly.

Source files
------------

// File: rtl/dfh_chain_walker.sv
// Device Feature Header list walker: follows nxt_dfh_offset links from a base
// address with 64-bit CSR reads, streams each header and reports typed status.
module dfh_chain_walker #(
  parameter int ADDR_W      = 32,
  parameter int MAX_DFH     = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CNT_W      = $clog2(MAX_DFH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic [63:0]       rd_rsp_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic              entry_valid,
  output logic [CNT_W-1:0]  entry_idx,
  output logic [ADDR_W-1:0] entry_addr,
  output logic [63:0]       entry_dfh,
  output logic [CNT_W-1:0]  dfh_count,
  output logic [2:0]        dbg_state
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SUM_W = ((ADDR_W > 24) ? ADDR_W : 24) + 1;

  localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_MAXLEN   = 3'd2;
  localparam logic [2:0] ERR_ADDR_OVF = 3'd3;
  localparam logic [2:0] ERR_MISALIGN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ev_q, ev_d;
  logic [CNT_W-1:0]  eidx_q, eidx_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;
  logic [63:0]       edfh_q, edfh_d;

  logic [23:0]       nxt_off;
  logic              eol;
  logic [SUM_W-1:0]  sum;
  logic              ovf;
  logic [CNT_W-1:0]  cnt_inc;

  assign nxt_off = rd_rsp_data[39:16];
  assign eol     = rd_rsp_data[40];
  // Wide sum so any carry beyond the address space is visible.
  assign sum     = SUM_W'(cur_q) + SUM_W'(nxt_off);
  assign ovf     = |sum[SUM_W-1:ADDR_W];
  assign cnt_inc = (cnt_q == CNT_W'(MAX_DFH)) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      tmr_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      ev_q    <= 1'b0;
      eidx_q  <= '0;
      eaddr_q <= '0;
      edfh_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tmr_q   <= tmr_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      eidx_q  <= eidx_d;
      eaddr_q <= eaddr_d;
      edfh_q  <= edfh_d;
    end
  end

  // Read port: a request transfers on a cycle with rd_req_valid && rd_req_ready;
  // valid and address stay stable until then. Responses carry no ready and are
  // consumed only while the single outstanding read is pending (S_WAIT).
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tmr_d   = tmr_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    ev_d    = 1'b0;
    eidx_d  = eidx_q;
    eaddr_d = eaddr_q;
    edfh_d  = edfh_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          cur_d  = base_addr;
          code_d = '0;
          cnt_d  = '0;
          if (base_addr[2:0] != 3'd0) begin
            state_d = S_ERR;
            code_d  = ERR_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (rd_req_ready) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end
      end
      S_WAIT: begin
        if (rd_rsp_valid) begin
          ev_d    = 1'b1;
          eidx_d  = cnt_q;
          eaddr_d = cur_q;
          edfh_d  = rd_rsp_data;
          cnt_d   = cnt_inc;
          // The header is always reported, even when it ends the walk.
          if (eol || (nxt_off == 24'd0)) begin
            state_d = S_DONE;
          end else if (cnt_q == CNT_W'(MAX_DFH - 1)) begin
            state_d = S_ERR;
            code_d  = ERR_MAXLEN;
          end else if (nxt_off[2:0] != 3'd0) begin
            state_d = S_ERR;
            code_d  = ERR_MISALIGN;
          end else if (ovf) begin
            state_d = S_ERR;
            code_d  = ERR_ADDR_OVF;
          end else begin
            cur_d   = sum[ADDR_W-1:0];
            state_d = S_REQ;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
          code_d  = ERR_TIMEOUT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_req_valid = (state_q == S_REQ);
  assign rd_req_addr  = cur_q;
  assign busy         = (state_q == S_REQ) || (state_q == S_WAIT);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign err_code     = code_q;
  assign entry_valid  = ev_q;
  assign entry_idx    = eidx_q;
  assign entry_addr   = eaddr_q;
  assign entry_dfh    = edfh_q;
  assign dfh_count    = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dfh_chain_walker.sv
// Bench for dfh_chain_walker: CSR memory responder, chain-walk reference model
// with an expected-entry queue, and a single compare process that owns the counts.
module tb_dfh_chain_walker;

  localparam int ADDR_W      = 16;
  localparam int MAX_DFH     = 4;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_W       = $clog2(MAX_DFH + 1);
  localparam int EW          = CNT_W + ADDR_W + 64;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic [63:0]       rd_rsp_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        err_code;
  logic              entry_valid;
  logic [CNT_W-1:0]  entry_idx;
  logic [ADDR_W-1:0] entry_addr;
  logic [63:0]       entry_dfh;
  logic [CNT_W-1:0]  dfh_count;
  logic [2:0]        dbg_state;

  dfh_chain_walker #(
    .ADDR_W      (ADDR_W),
    .MAX_DFH     (MAX_DFH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .entry_valid  (entry_valid),
    .entry_idx    (entry_idx),
    .entry_addr   (entry_addr),
    .entry_dfh    (entry_dfh),
    .dfh_count    (dfh_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  logic [63:0]   mem [int];
  logic [EW-1:0] exp_q[$];
  chk_t          chk_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          rsp_en = 1'b1;
  int            rsp_lat = 2;
  int            stray_req = 0;
  int            stray_ack = 0;
  logic          m_done, m_err;
  logic [2:0]    m_code;
  int            m_count;

  function automatic logic [63:0] mk_dfh(input logic [11:0] id, input logic [23:0] off,
                                         input logic eol, input logic [3:0] ftype);
    return {ftype, 19'h0, eol, off, 4'h1, id};
  endfunction

  // Reference walk over the bench memory: fills exp_q and the final status.
  task automatic run_model(input int base);
    int cur;
    int off;
    logic [63:0] d;
    m_done = 1'b0; m_err = 1'b0; m_code = 3'd0; m_count = 0;
    if (base % 8 != 0) begin
      m_err = 1'b1; m_code = 3'd4;
      return;
    end
    cur = base;
    forever begin
      d = mem.exists(cur) ? mem[cur] : 64'h0;
      exp_q.push_back({CNT_W'(m_count), ADDR_W'(cur), d});
      m_count++;
      off = int'(d[39:16]);
      if (d[40] || off == 0) begin m_done = 1'b1; return; end
      if (m_count == MAX_DFH) begin m_err = 1'b1; m_code = 3'd2; return; end
      if (off % 8 != 0) begin m_err = 1'b1; m_code = 3'd4; return; end
      if (cur + off > (1 << ADDR_W) - 1) begin m_err = 1'b1; m_code = 3'd3; return; end
      cur = cur + off;
    end
  endtask

  // ---------------- CSR responder ----------------
  initial begin : responder
    logic [ADDR_W-1:0] a;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        stray_ack = stray_ack + 1;
        @(posedge clk); #1;
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = 64'hDEAD_0000_0010_BEEF;
        @(posedge clk); #1;
        rd_rsp_valid = 1'b0;
      end else if (rsp_en && rd_req_valid && rd_req_ready) begin
        a = rd_req_addr;
        @(posedge clk);
        repeat (rsp_lat - 1) @(posedge clk);
        #1;
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = mem.exists(int'(a)) ? mem[int'(a)] : 64'h0;
        @(posedge clk); #1;
        rd_rsp_valid = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin : compare
    chk_t          c;
    logic [EW-1:0] e;
    logic          prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (entry_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL entry_extra: got idx=%0d addr=%h dfh=%h, required no entry",
                   entry_idx, entry_addr, entry_dfh);
        end else begin
          e = exp_q.pop_front();
          if ({entry_idx, entry_addr, entry_dfh} !== e) begin
            n_bad++;
            $display("FAIL entry: got %h, required %h", {entry_idx, entry_addr, entry_dfh}, e);
          end
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (rd_req_valid !== 1'b1 || rd_req_addr !== prev_addr) begin
          n_bad++;
          $display("FAIL req_hold: got valid=%b addr=%h, required valid=1 addr=%h",
                   rd_req_valid, rd_req_addr, prev_addr);
        end
      end
      prev_stall = rd_req_valid && !rd_req_ready && !rst;
      prev_addr  = rd_req_addr;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_cmp++;
        if (c.act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, required %h", c.name, c.act, c.exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_status(input string tag, input int cyc, input int exp_cyc);
    @(negedge clk);
    push_chk({tag, "_busy"},   64'(busy), 64'd0);
    push_chk({tag, "_done"},   64'(done), 64'(m_done));
    push_chk({tag, "_err"},    64'(err), 64'(m_err));
    push_chk({tag, "_code"},   64'(err_code), 64'(m_code));
    push_chk({tag, "_count"},  64'(dfh_count), 64'(m_count));
    push_chk({tag, "_left"},   64'(exp_q.size()), 64'd0);
    push_chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic check_zero(input string tag);
    push_chk({tag, "_flags"}, 64'({busy, done, err, rd_req_valid, entry_valid}), 64'd0);
    push_chk({tag, "_code"},  64'(err_code), 64'd0);
    push_chk({tag, "_count"}, 64'(dfh_count), 64'd0);
    push_chk({tag, "_eidx"},  64'(entry_idx), 64'd0);
    push_chk({tag, "_eaddr"}, 64'(entry_addr), 64'd0);
    push_chk({tag, "_edfh"},  entry_dfh, 64'd0);
    push_chk({tag, "_raddr"}, 64'(rd_req_addr), 64'd0);
  endtask

  task automatic load_chain3();
    mem.delete();
    mem[32'h0000] = mk_dfh(12'h001, 24'h001000, 1'b0, 4'h4);
    mem[32'h1000] = mk_dfh(12'h002, 24'h002000, 1'b0, 4'h3);
    mem[32'h3000] = mk_dfh(12'h003, 24'h000040, 1'b1, 4'h4);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    logic [EW-1:0] e;
    rst = 1'b1; start = 1'b0; base_addr = '0; rd_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three-header chain ending on eol.
    load_chain3();
    run_model(0);
    push_chk("pin_t1_n", 64'(exp_q.size()), 64'd3);
    e = exp_q[2];
    push_chk("pin_t1_addr2", 64'(e[64 +: ADDR_W]), 64'h3000);
    do_start(16'h0000);
    wait_idle(200, n);
    check_status("t1", n, 9);

    // Read never answered: timeout, then a late response must be dropped.
    mem.delete();
    mem[32'h0100] = mk_dfh(12'h010, 24'h0, 1'b1, 4'h4);
    rsp_en = 1'b0;
    m_done = 1'b0; m_err = 1'b1; m_code = 3'd1; m_count = 0;
    do_start(16'h0100);
    wait_idle(1100, n);
    check_status("t2", n, 1025);
    stray_req++;
    repeat (4) @(negedge clk);
    check_status("t2_late", n, 1025);
    rsp_en = 1'b1;

    // Endless chain hits the header limit.
    mem.delete();
    for (int i = 0; i < 6; i++)
      mem[i * 32'h1000] = mk_dfh(12'(i), 24'h001000, 1'b0, 4'h3);
    run_model(0);
    push_chk("pin_t3_code", 64'(m_code), 64'd2);
    push_chk("pin_t3_count", 64'(m_count), 64'd4);
    do_start(16'h0000);
    wait_idle(200, n);
    check_status("t3", n, 12);

    // Link past the top of the address space.
    mem.delete();
    mem[32'hF000] = mk_dfh(12'h0F0, 24'h002000, 1'b0, 4'h4);
    run_model(32'hF000);
    push_chk("pin_t4a_code", 64'(m_code), 64'd3);
    do_start(16'hF000);
    wait_idle(200, n);
    check_status("t4a", n, 3);

    // Misaligned link offset.
    mem[32'hF000] = mk_dfh(12'h0F1, 24'h001004, 1'b0, 4'h4);
    run_model(32'hF000);
    push_chk("pin_t4b_code", 64'(m_code), 64'd4);
    do_start(16'hF000);
    wait_idle(200, n);
    check_status("t4b", n, 3);

    // Misaligned base: no read at all.
    mem.delete();
    run_model(32'h0104);
    push_chk("pin_t4c_count", 64'(m_count), 64'd0);
    do_start(16'h0104);
    wait_idle(200, n);
    check_status("t4c", n, 0);

    // Stalled request, ignored start, reset while waiting, fresh walk.
    mem.delete();
    mem[32'h2000] = mk_dfh(12'h020, 24'h0, 1'b1, 4'h4);
    rsp_en = 1'b0;
    rd_req_ready = 1'b0;
    do_start(16'h2000);
    repeat (2) @(negedge clk);
    start = 1'b1; base_addr = 16'h0800;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    push_chk("t5_stall_addr", 64'(rd_req_addr), 64'h2000);
    @(posedge clk); #1;
    rd_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    push_chk("t5_inwait", 64'({busy, rd_req_valid}), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t5_rst");
    rst = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    check_zero("t5_late");
    rsp_en = 1'b1;
    rsp_lat = 1;
    load_chain3();
    run_model(0);
    do_start(16'h0000);
    wait_idle(200, n);
    check_status("t5_new", n, 6);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
